// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage latch with 2-entry skid buffer, flush, enable and sticky halt
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic              in_halt_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic              out_halt_o,
  output logic [1:0]        occupancy_o
);
  logic              main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic              main_halt_q, main_halt_d, skid_halt_q, skid_halt_d;
  logic              halt_seen_q, halt_seen_d;
  logic              acc, pop;
  // Handshake depends only on flops and en/flush so it never loops back through the producer.
  always_comb begin
    in_ready_o  = en_i & ~flush_i & ~skid_v_q & ~halt_seen_q;
    acc         = in_valid_i & in_ready_o;
    pop         = en_i & ~flush_i & main_v_q & out_ready_i;
    out_valid_o = main_v_q;
    out_data_o  = main_data_q;
    out_ctrl_o  = main_v_q ? main_ctrl_q : '0;
    out_halt_o  = (main_v_q & main_halt_q) | halt_seen_q;
    occupancy_o = {1'b0, main_v_q} + {1'b0, skid_v_q};
  end
  // Next state: flush beats stall beats normal update; ctrl/halt are cleared whenever an entry goes invalid.
  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    main_halt_d = main_halt_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_halt_d = skid_halt_q;
    halt_seen_d = halt_seen_q | (pop & main_halt_q);
    if (flush_i) begin
      main_v_d    = 1'b0;
      main_ctrl_d = '0;
      main_halt_d = 1'b0;
      skid_v_d    = 1'b0;
      skid_ctrl_d = '0;
      skid_halt_d = 1'b0;
    end else if (en_i) begin
      if ((pop | ~main_v_q) & acc) begin
        main_v_d    = 1'b1;
        main_data_d = in_data_i;
        main_ctrl_d = in_ctrl_i;
        main_halt_d = in_halt_i;
      end else if (acc) begin
        skid_v_d    = 1'b1;
        skid_data_d = in_data_i;
        skid_ctrl_d = in_ctrl_i;
        skid_halt_d = in_halt_i;
      end else if (pop) begin
        main_v_d    = skid_v_q;
        main_data_d = skid_v_q ? skid_data_q : main_data_q;
        main_ctrl_d = skid_v_q ? skid_ctrl_q : '0;
        main_halt_d = skid_v_q & skid_halt_q;
        skid_v_d    = 1'b0;
        skid_ctrl_d = '0;
        skid_halt_d = 1'b0;
      end
    end
  end
  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_v_q    <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      main_halt_q <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_halt_q <= 1'b0;
      halt_seen_q <= 1'b0;
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      main_halt_q <= main_halt_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_halt_q <= skid_halt_d;
      halt_seen_q <= halt_seen_d;
    end
  end
endmodule
